// File: rtl/ysyx_25030081_lsu_pkg.sv
// Shared LSU definitions: req_op width codes, FSM state encodings, decode helpers.
// Used by the decoder and by the LSU top and its lane-alignment sub-module.
// No ports (package).
package ysyx_25030081_lsu_pkg;

  // req_op width codes: bit2 = unsigned load, bit1 = word, bit0 = half
  localparam logic [2:0] OP_B  = 3'b000;
  localparam logic [2:0] OP_H  = 3'b001;
  localparam logic [2:0] OP_W  = 3'b010;
  localparam logic [2:0] OP_BU = 3'b100;
  localparam logic [2:0] OP_HU = 3'b101;

  // LSU FSM state encodings
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic [1:0] ST_RESP = 2'd3;

  // Unsigned widths exist only for loads; a store with bit2 set is illegal.
  function automatic logic op_legal(input logic [2:0] op, input logic is_store);
    logic ok;
    case (op)
      OP_B, OP_H, OP_W: ok = 1'b1;
      OP_BU, OP_HU:     ok = !is_store;
      default:          ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Natural alignment check; only meaningful for legal codes.
  function automatic logic addr_aligned(input logic [2:0] op, input logic [1:0] lo);
    logic ok;
    if (op[1])
      ok = (lo == 2'b00);
    else if (op[0])
      ok = !lo[0];
    else
      ok = 1'b1;
    return ok;
  endfunction

endpackage

// File: rtl/ysyx_25030081_lsu_align.sv
// Combinational lane alignment: store data replication + byte strobes, load
// byte/half extraction with sign or zero extension.
// Ports: op/offset select width and lane; store gates wstrb; wdata/rdata in, lane_wdata/wstrb/load_data out.
module ysyx_25030081_lsu_align
  import ysyx_25030081_lsu_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [1:0]  offset,
  input  logic        store,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [31:0] lane_wdata,
  output logic [3:0]  wstrb,
  output logic [31:0] load_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic        sign_ext;

  always_comb begin
    byte_sel = rdata[7:0];
    case (offset)
      2'd0: byte_sel = rdata[7:0];
      2'd1: byte_sel = rdata[15:8];
      2'd2: byte_sel = rdata[23:16];
      2'd3: byte_sel = rdata[31:24];
      default: byte_sel = rdata[7:0];
    endcase
  end

  assign half_sel = offset[1] ? rdata[31:16] : rdata[15:0];
  assign sign_ext = !op[2];

  // Replicating the data across all lanes lets the bus pick any lane by
  // strobe alone, so only the strobe depends on the address.
  always_comb begin
    lane_wdata = '0;
    wstrb      = 4'b0000;
    if (store) begin
      if (op[1]) begin
        lane_wdata = wdata;
        wstrb      = 4'b1111;
      end else if (op[0]) begin
        lane_wdata = {2{wdata[15:0]}};
        wstrb      = offset[1] ? 4'b1100 : 4'b0011;
      end else begin
        lane_wdata = {4{wdata[7:0]}};
        wstrb      = 4'b0001 << offset;
      end
    end
  end

  always_comb begin
    load_data = '0;
    if (op[1])
      load_data = rdata;
    else if (op[0])
      load_data = {{16{sign_ext & half_sel[15]}}, half_sel};
    else
      load_data = {{24{sign_ext & byte_sel[7]}}, byte_sel};
  end

endmodule

// File: rtl/ysyx_25030081_lsu.sv
// Load/store unit: accepts one core request at a time, issues one bus access
// (req/gnt then rvalid) and returns a one-cycle response with data or fault.
// Ports: core req_* handshake in, resp_* pulse out; mem_* bus request out, mem_gnt/rvalid/rdata in.
module ysyx_25030081_lsu
  import ysyx_25030081_lsu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_ren,
  input  logic            req_wen,
  input  logic [2:0]      req_op,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            resp_valid,
  output logic [XLEN-1:0] resp_rdata,
  output logic            resp_err,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  output logic [3:0]      mem_wstrb,
  input  logic            mem_gnt,
  input  logic            mem_rvalid,
  input  logic [XLEN-1:0] mem_rdata
);

  logic [1:0]      state;
  logic [XLEN-1:0] addr_q;
  logic [XLEN-1:0] wdata_q;
  logic [XLEN-1:0] rdata_q;
  logic [2:0]      op_q;
  logic            ren_q;
  logic            wen_q;
  logic            err_q;

  logic            req_any;
  logic            req_ok;
  logic [XLEN-1:0] lane_wdata;
  logic [3:0]      lane_wstrb;
  logic [XLEN-1:0] load_data;

  // A request with neither ren nor wen is swallowed silently; one with both
  // is accepted but faulted (req_ok requires exactly one).
  assign req_any = req_valid && (req_ren || req_wen);
  assign req_ok  = (req_ren ^ req_wen)
                && op_legal(req_op, req_wen)
                && addr_aligned(req_op, req_addr[1:0]);

  ysyx_25030081_lsu_align u_align (
    .op         (op_q),
    .offset     (addr_q[1:0]),
    .store      (wen_q),
    .wdata      (wdata_q),
    .rdata      (mem_rdata),
    .lane_wdata (lane_wdata),
    .wstrb      (lane_wstrb),
    .load_data  (load_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      op_q    <= 3'b000;
      ren_q   <= 1'b0;
      wen_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_any) begin
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            op_q    <= req_op;
            ren_q   <= req_ren;
            wen_q   <= req_wen;
            rdata_q <= '0;
            if (req_ok) begin
              state <= ST_REQ;
              err_q <= 1'b0;
            end else begin
              // faults skip the bus entirely
              state <= ST_RESP;
              err_q <= 1'b1;
            end
          end
        end
        ST_REQ: begin
          if (mem_gnt)
            state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (mem_rvalid) begin
            // stores use rvalid only as a completion marker
            rdata_q <= ren_q ? load_data : '0;
            state   <= ST_RESP;
          end
        end
        ST_RESP: begin
          state   <= ST_IDLE;
          err_q   <= 1'b0;
          rdata_q <= '0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Bus outputs are driven only while requesting so they read as zero in
  // every other state, including reset; registers keep them stable until gnt.
  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wstrb = 4'b0000;
    if (state == ST_REQ) begin
      mem_req   = 1'b1;
      mem_we    = wen_q;
      mem_addr  = {addr_q[XLEN-1:2], 2'b00};
      mem_wdata = lane_wdata;
      mem_wstrb = lane_wstrb;
    end
  end

  assign req_ready  = (state == ST_IDLE);
  assign resp_valid = (state == ST_RESP);
  assign resp_rdata = (state == ST_RESP) ? rdata_q : '0;
  assign resp_err   = (state == ST_RESP) && err_q;

endmodule

// File: tb/tb_ysyx_25030081_lsu.sv
// Bench for the LSU: directed cases plus randomized transactions compared
// against an arithmetic reference model of the lane and extension rules.
module tb_ysyx_25030081_lsu;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_ren = 1'b0;
  logic        req_wen = 1'b0;
  logic [2:0]  req_op = 3'b000;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_gnt = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ysyx_25030081_lsu #(.XLEN(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_ren    (req_ren),
    .req_wen    (req_wen),
    .req_op     (req_op),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_wstrb  (mem_wstrb),
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model: expected legality, strobes, lane data and load result.
  function automatic void model(input logic ren, input logic wen, input logic [2:0] op,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [31:0] rdata, output logic ok,
                                output logic [3:0] strb, output logic [31:0] wd,
                                output logic [31:0] rd);
    int size;
    int off;
    logic [31:0] mask;
    logic [31:0] v;
    off  = int'(addr % 4);
    size = op[1] ? 4 : (op[0] ? 2 : 1);
    ok   = (ren != wen);
    if (wen)
      ok = ok && (op == 3'd0 || op == 3'd1 || op == 3'd2);
    else
      ok = ok && (op == 3'd0 || op == 3'd1 || op == 3'd2 || op == 3'd4 || op == 3'd5);
    ok   = ok && ((off % size) == 0);
    strb = 4'h0;
    wd   = '0;
    rd   = '0;
    if (wen) begin
      if (size == 1) begin
        strb = 4'(1 << off);
        wd   = (wdata & 32'hFF) * 32'h01010101;
      end else if (size == 2) begin
        strb = 4'(3 << off);
        wd   = (wdata & 32'hFFFF) * 32'h00010001;
      end else begin
        strb = 4'hF;
        wd   = wdata;
      end
    end else begin
      mask = (size == 4) ? 32'hFFFFFFFF : ((32'h1 << (8 * size)) - 1);
      v    = (rdata >> (8 * off)) & mask;
      if (!op[2] && size < 4 && v[8 * size - 1])
        v = v | ~mask;
      rd = v;
    end
  endfunction

  // One full transaction. poke = drive a competing req_valid and spurious
  // rvalid during the gnt stall, and spurious gnt during the rvalid stall.
  task automatic run_txn(input logic ren, input logic wen, input logic [2:0] op,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] rdata, input int gnt_dly, input int rv_dly,
                         input logic poke, output logic [31:0] got_rd);
    logic        ok;
    logic [3:0]  strb;
    logic [31:0] wd;
    logic [31:0] rd;
    model(ren, wen, op, addr, wdata, rdata, ok, strb, wd, rd);
    got_rd = 'x;
    @(negedge clk);
    check("ready_idle", req_ready, 1);
    req_valid = 1'b1; req_ren = ren; req_wen = wen; req_op = op;
    req_addr = addr; req_wdata = wdata;
    @(negedge clk);
    req_valid = 1'b0; req_ren = 1'b0; req_wen = 1'b0;
    req_addr = $urandom; req_wdata = $urandom;
    check("ready_busy", req_ready, 0);
    if (!ok) begin
      check("fault_valid", resp_valid, 1);
      check("fault_err", resp_err, 1);
      check("fault_rdata", resp_rdata, 0);
      check("fault_noreq", mem_req, 0);
      got_rd = resp_rdata;
      @(negedge clk);
      check("fault_valid_drop", resp_valid, 0);
      check("fault_err_drop", resp_err, 0);
      return;
    end
    check("req_assert", mem_req, 1);
    check("req_addr", mem_addr, {addr[31:2], 2'b00});
    check("req_we", mem_we, wen);
    check("req_wstrb", mem_wstrb, strb);
    if (wen) check("req_wdata", mem_wdata, wd);
    check("no_resp_req", resp_valid, 0);
    for (int i = 0; i < gnt_dly; i++) begin
      if (poke) begin
        req_valid = 1'b1; req_ren = 1'b1; mem_rvalid = 1'b1;
      end
      @(negedge clk);
      check("stall_req", mem_req, 1);
      check("stall_addr", mem_addr, {addr[31:2], 2'b00});
      check("stall_wstrb", mem_wstrb, strb);
      if (wen) check("stall_wdata", mem_wdata, wd);
      check("stall_ready", req_ready, 0);
      check("stall_noresp", resp_valid, 0);
    end
    req_valid = 1'b0; req_ren = 1'b0; mem_rvalid = 1'b0;
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    check("wait_noreq", mem_req, 0);
    check("wait_noresp", resp_valid, 0);
    check("wait_ready", req_ready, 0);
    for (int i = 0; i < rv_dly; i++) begin
      mem_gnt = poke;
      @(negedge clk);
      check("wait_stall_noresp", resp_valid, 0);
      check("wait_stall_noreq", mem_req, 0);
    end
    mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = rdata;
    @(negedge clk);
    mem_rvalid = 1'b0; mem_rdata = $urandom;
    check("resp_valid", resp_valid, 1);
    check("resp_rdata", resp_rdata, rd);
    check("resp_err", resp_err, 0);
    got_rd = resp_rdata;
    @(negedge clk);
    check("resp_drop", resp_valid, 0);
    check("resp_rdata_zero", resp_rdata, 0);
    check("ready_back", req_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] got;
    logic [2:0]  legal_ops [5];
    legal_ops[0] = 3'b000; legal_ops[1] = 3'b001; legal_ops[2] = 3'b010;
    legal_ops[3] = 3'b100; legal_ops[4] = 3'b101;

    // reset state
    repeat (2) @(negedge clk);
    check("rst_ready", req_ready, 1);
    check("rst_mem_req", mem_req, 0);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_resp_rdata", resp_rdata, 0);
    check("rst_resp_err", resp_err, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_mem_wstrb", mem_wstrb, 0);
    rst_n = 1'b1;

    // sw at minimum latency
    run_txn(0, 1, 3'b010, 32'h80000004, 32'hDEADBEEF, 32'h0, 0, 0, 0, got);
    check("sw_rdata", got, 32'h0);
    // lb / lbu on top byte
    run_txn(1, 0, 3'b000, 32'h80000003, 32'h0, 32'h80FF0000, 0, 0, 0, got);
    check("lb_const", got, 32'hFFFFFF80);
    run_txn(1, 0, 3'b100, 32'h80000003, 32'h0, 32'h80FF0000, 0, 0, 0, got);
    check("lbu_const", got, 32'h00000080);
    // sh upper half, lh/lhu
    run_txn(0, 1, 3'b001, 32'h80000002, 32'h0000ABCD, 32'h0, 0, 1, 0, got);
    run_txn(1, 0, 3'b001, 32'h80000002, 32'h0, 32'h80011234, 1, 0, 0, got);
    check("lh_const", got, 32'hFFFF8001);
    run_txn(1, 0, 3'b101, 32'h80000002, 32'h0, 32'h80011234, 0, 0, 0, got);
    check("lhu_const", got, 32'h00008001);
    // misaligned word and reserved op code
    run_txn(1, 0, 3'b010, 32'h80000002, 32'h0, 32'h0, 0, 0, 0, got);
    run_txn(1, 0, 3'b011, 32'h80000000, 32'h0, 32'h0, 0, 0, 0, got);
    // unsigned store and both ren/wen are faults
    run_txn(0, 1, 3'b100, 32'h80000000, 32'h12, 32'h0, 0, 0, 0, got);
    run_txn(1, 1, 3'b010, 32'h80000000, 32'h12, 32'h0, 0, 0, 0, got);
    // gnt delayed 3 cycles with a competing request held up
    run_txn(1, 0, 3'b010, 32'h80000010, 32'h0, 32'h13572468, 3, 2, 1, got);
    check("lw_stall_const", got, 32'h13572468);

    // neither ren nor wen: consumed, no response
    @(negedge clk);
    req_valid = 1'b1; req_ren = 1'b0; req_wen = 1'b0; req_op = 3'b010;
    @(negedge clk);
    req_valid = 1'b0;
    check("nop_ready", req_ready, 1);
    check("nop_noresp", resp_valid, 0);
    check("nop_noreq", mem_req, 0);

    // reset while in WAIT abandons the access
    req_valid = 1'b1; req_ren = 1'b1; req_op = 3'b010; req_addr = 32'h80000020;
    @(negedge clk);
    req_valid = 1'b0; req_ren = 1'b0; mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    check("mid_wait_ready", req_ready, 0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_ready", req_ready, 1);
    check("mid_rst_req", mem_req, 0);
    check("mid_rst_resp", resp_valid, 0);
    @(negedge clk);
    rst_n = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'hCAFEF00D;
    @(negedge clk);
    mem_rvalid = 1'b0;
    check("late_rvalid_noresp", resp_valid, 0);
    @(negedge clk);
    check("late_rvalid_noresp2", resp_valid, 0);
    check("late_rvalid_ready", req_ready, 1);

    // randomized transactions
    for (int n = 0; n < 80; n++) begin
      int sel;
      logic r, w;
      logic [2:0] op;
      sel = $urandom_range(0, 9);
      r = (sel <= 5) || (sel == 9);
      w = (sel >= 6);
      op = ($urandom_range(0, 4) == 0) ? 3'($urandom_range(0, 7))
                                       : legal_ops[$urandom_range(0, 4)];
      run_txn(r, w, op, $urandom, $urandom, $urandom,
              $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)), got);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ysyx_25030081_lsu.md
YSYX_25030081_LSU -- requirements
Module: ysyx_25030081_lsu

Interface
REQ-001 Parameter XLEN, default 32, datapath and address width; only 32 is supported.
REQ-002 One clock; reset is asynchronous and active-low. Ports: clk in 1 system clock; rst_n in 1 reset.
REQ-003 req_valid in 1: core presents a memory request.
REQ-004 req_ready out 1: LSU accepts a request this cycle.
REQ-005 req_ren in 1 load; req_wen in 1 store (decoder mem_ren/mem_wen).
REQ-006 req_op in 3: width code (decoder mem_op): bit2 unsigned load, bit1 word, bit0 half.
REQ-007 req_addr in 32 byte address; req_wdata in 32 store data in low bits.
REQ-008 resp_valid out 1 one-cycle completion pulse; resp_rdata out 32 extended load data; resp_err out 1 access fault.
REQ-009 mem_req out 1; mem_we out 1; mem_addr out 32 word-aligned; mem_wdata out 32 lane-aligned; mem_wstrb out 4.
REQ-010 mem_gnt in 1 bus accepts mem_req; mem_rvalid in 1 completion (loads and stores); mem_rdata in 32 full word.

Function
REQ-011 Legal req_op: 000 lb/sb, 001 lh/sh, 010 lw/sw, 100 lbu, 101 lhu; all other codes, or a store with bit2 = 1, are illegal.
REQ-012 FSM states IDLE, REQ, WAIT, RESP; req_ready = 1 only in IDLE.
REQ-013 IDLE: on req_valid with exactly one of ren/wen set, register addr, wdata, op and ren/wen; go to REQ if legal and aligned, else to RESP with err.
REQ-014 IDLE: req_valid with neither ren nor wen is consumed with no action and no response.
REQ-015 IDLE: req_valid with both ren and wen set is handled as an illegal access (RESP, err = 1).
REQ-016 Misaligned: half with addr[0] = 1, or word with addr[1:0] != 0, gives no bus access and err = 1.
REQ-017 REQ: mem_req = 1; mem_we, mem_addr ({addr[31:2],2'b00}), mem_wdata and mem_wstrb are held stable until mem_gnt; on mem_gnt go to WAIT.
REQ-018 WAIT: mem_req = 0; on mem_rvalid capture the extended load data and go to RESP.
REQ-019 RESP: resp_valid = 1 for exactly one cycle, then IDLE; resp_rdata and resp_err stay valid only during that cycle and are 0 otherwise.
REQ-020 Store lanes:
- byte: wstrb = 1 << addr[1:0], wdata = byte replicated x4;
- half: wstrb = 0011 or 1100 by addr[1], wdata = half replicated x2;
- word: wstrb = 1111.
REQ-021 Loads: mem_wstrb = 0000; select the byte or half by addr[1:0]; sign-extend when op[2] = 0, zero-extend when op[2] = 1.
REQ-022 Stores: resp_rdata = 0; mem_rvalid only marks completion.
REQ-023 Fault response: resp_rdata = 0, resp_err = 1, one cycle after acceptance.
REQ-024 Minimum latency: accept at T, mem_req and gnt at T+1, rvalid at T+2, resp_valid at T+3. Unbounded gnt/rvalid stalls are tolerated.
REQ-025 mem_rvalid outside WAIT and mem_gnt outside REQ are ignored.
REQ-026 No request is accepted while busy; the core holds req_valid until req_ready.

Reset
REQ-027 rst_n low: state IDLE immediately; mem_req, resp_valid, resp_err, resp_rdata, mem_we, mem_wstrb, mem_addr and mem_wdata are 0; req_ready = 1.
REQ-028 Reset mid-transaction abandons it with no response; a late mem_rvalid after reset is ignored.

Structure
REQ-029 The shared defines header holds the req_op width codes and the FSM state encodings, for use by the decoder and the LSU.
REQ-030 One combinational sub-module, ysyx_25030081_lsu_align, does store lane/wstrb generation and load extraction/extension. The FSM and registers stay in the top.

Verification
REQ-031 sw 0x80000004, wdata 0xDEADBEEF, gnt at T+1, rvalid at T+2 -> mem_addr 0x80000004, wstrb 1111, wdata 0xDEADBEEF; resp_valid at T+3, err 0.
REQ-032 lb 0x80000003 with mem_rdata 0x80FF0000 -> resp_rdata 0xFFFFFF80; lbu on the same access -> 0x00000080.
REQ-033 sh 0x80000002, wdata 0x0000ABCD -> wstrb 1100, wdata 0xABCDABCD. lh 0x80000002 with rdata 0x8001_1234 -> 0xFFFF8001; lhu -> 0x00008001.
REQ-034 lw 0x80000002 -> mem_req never asserts; resp_valid at T+1, err 1, rdata 0. req_op 011 behaves the same.
REQ-035 gnt delayed 3 cycles -> mem_req and address/data stable throughout; req_ready 0 while busy; a second req_valid is not accepted.
REQ-036 rst_n low in WAIT -> mem_req 0 and state IDLE immediately; no resp_valid; a following mem_rvalid produces no response.
